// File: rtl/imm_encoder_pkg.sv
// Shared immediate-format definitions for the RISC-V immediate encoder and decoder.
// Format codes, request/result payloads and the signed-range helper live here.
package imm_encoder_pkg;

   localparam int unsigned XLEN  = 32;
   localparam int unsigned SRC_W = 3;

   typedef enum logic [SRC_W-1:0] {
      FMT_I    = 3'b000,
      FMT_S    = 3'b001,
      FMT_B    = 3'b010,
      FMT_U    = 3'b011,
      FMT_J    = 3'b100,
      FMT_RAW0 = 3'b101,
      FMT_RAW1 = 3'b110,
      FMT_RAW2 = 3'b111
   } imm_fmt_e;

   typedef struct packed {
      logic [XLEN-1:0] tmpl;
      logic [XLEN-1:0] imm;
      imm_fmt_e        fmt;
   } imm_req_t;

   typedef struct packed {
      logic [XLEN-1:0] inst;
      logic            err;
   } imm_res_t;

   // True when v[XLEN-1:msb] are all equal, i.e. v fits a signed field whose sign bit is msb.
   function automatic logic fits_signed(input logic [XLEN-1:0] v, input int unsigned msb);
      logic [XLEN-1:0] hi;
      hi = XLEN'($signed(v) >>> msb);
      return (hi == '0) || (hi == '1);
   endfunction

endpackage

// File: rtl/imm_pack.sv
// Combinational immediate packer: scatters the immediate into the template's
// format-specific fields and flags values the format cannot represent.
module imm_pack
   import imm_encoder_pkg::*;
(
   input  imm_req_t req,
   output imm_res_t res
);

   always_comb begin
      res.inst = req.tmpl;
      res.err  = 1'b0;
      case (req.fmt)
         FMT_I: begin
            res.inst[31:20] = req.imm[11:0];
            res.err         = !fits_signed(req.imm, 11);
         end
         FMT_S: begin
            res.inst[31:25] = req.imm[11:5];
            res.inst[11:7]  = req.imm[4:0];
            res.err         = !fits_signed(req.imm, 11);
         end
         FMT_B: begin
            res.inst[31]    = req.imm[12];
            res.inst[7]     = req.imm[11];
            res.inst[30:25] = req.imm[10:5];
            res.inst[11:8]  = req.imm[4:1];
            res.err         = !fits_signed(req.imm, 12) || req.imm[0];
         end
         FMT_U: begin
            res.inst[31:12] = req.imm[31:12];
            res.err         = (req.imm[11:0] != 12'h000);
         end
         FMT_J: begin
            res.inst[31]    = req.imm[20];
            res.inst[19:12] = req.imm[19:12];
            res.inst[20]    = req.imm[11];
            res.inst[30:21] = req.imm[10:1];
            res.err         = !fits_signed(req.imm, 20) || req.imm[0];
         end
         default: begin
            // Raw formats carry the low 25 bits unsigned above the opcode.
            res.inst[31:7] = req.imm[24:0];
            res.err        = (req.imm[31:25] != 7'h00);
         end
      endcase
   end

endmodule

// File: rtl/imm_encoder.sv
// Two-stage valid/ready immediate encoder: S1 captures the packed result,
// S2 presents it; also keeps a saturating count of delivered error results.
module imm_encoder
   import imm_encoder_pkg::*;
#(
   parameter int unsigned ERR_CNT_W = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [XLEN-1:0]      in_tmpl,
   input  logic [XLEN-1:0]      in_imm,
   input  logic [SRC_W-1:0]     in_src,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [XLEN-1:0]      out_inst,
   output logic                 out_err,
   output logic [ERR_CNT_W-1:0] err_cnt
);

   imm_req_t pack_req;
   imm_res_t pack_res;
   imm_res_t s1_res;
   logic     s1_valid;
   logic     s2_free;
   logic     s1_adv;
   logic     accept;
   logic     deliver;

   always_comb begin
      pack_req.tmpl = in_tmpl;
      pack_req.imm  = in_imm;
      pack_req.fmt  = imm_fmt_e'(in_src);
   end

   imm_pack u_pack (
      .req (pack_req),
      .res (pack_res)
   );

   // Handshake and stage-advance terms; empty stages always accept so bubbles collapse.
   assign s2_free  = !out_valid || out_ready;
   assign s1_adv   = s1_valid && s2_free;
   assign in_ready = !s1_valid || s1_adv;
   assign accept   = in_valid && in_ready;
   assign deliver  = out_valid && out_ready;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_valid  <= 1'b0;
         s1_res    <= '0;
         out_valid <= 1'b0;
         out_inst  <= '0;
         out_err   <= 1'b0;
         err_cnt   <= '0;
      end else begin
         if (in_ready) begin
            s1_valid <= in_valid;
         end
         if (accept) begin
            s1_res <= pack_res;
         end
         if (s2_free) begin
            out_valid <= s1_valid;
         end
         if (s1_adv) begin
            out_inst <= s1_res.inst;
            out_err  <= s1_res.err;
         end
         if (deliver && out_err && (err_cnt != '1)) begin
            err_cnt <= err_cnt + ERR_CNT_W'(1);
         end
      end
   end

endmodule

// File: tb/tb_imm_encoder.sv
// Scoreboard bench for imm_encoder: a driver queues expected results per accepted
// request, a monitor pops and compares them on every output handshake.
module tb_imm_encoder;
   import imm_encoder_pkg::*;

   localparam int unsigned ERR_CNT_W = 8;

   logic                 clk = 1'b0;
   logic                 rst;
   logic                 in_valid;
   logic                 in_ready;
   logic [31:0]          in_tmpl;
   logic [31:0]          in_imm;
   logic [2:0]           in_src;
   logic                 out_valid;
   logic                 out_ready;
   logic [31:0]          out_inst;
   logic                 out_err;
   logic [ERR_CNT_W-1:0] err_cnt;

   typedef struct {
      logic [31:0] inst;
      logic        err;
      logic [31:0] imm;
      logic [2:0]  src;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   failures = 0;
   int   exp_cnt = 0;
   logic next_ready = 1'b1;

   imm_encoder #(.ERR_CNT_W(ERR_CNT_W)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_tmpl   (in_tmpl),
      .in_imm    (in_imm),
      .in_src    (in_src),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_inst  (out_inst),
      .out_err   (out_err),
      .err_cnt   (err_cnt)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
      end
   endtask

   // Reference encoder written as whole-word concatenations.
   function automatic logic [31:0] enc_model(input logic [31:0] t, input logic [31:0] i,
                                             input logic [2:0] s);
      case (s)
         3'd0:    return {i[11:0], t[19:0]};
         3'd1:    return {i[11:5], t[24:12], i[4:0], t[6:0]};
         3'd2:    return {i[12], i[10:5], t[24:12], i[4:1], i[11], t[6:0]};
         3'd3:    return {i[31:12], t[11:0]};
         3'd4:    return {i[20], i[10:1], i[11], i[19:12], t[11:0]};
         default: return {i[24:0], t[6:0]};
      endcase
   endfunction

   function automatic logic err_model(input logic [31:0] i, input logic [2:0] s);
      logic [31:0] v;
      v = i;
      case (s)
         3'd0, 3'd1: return !((v[31:11] == 21'h0) || (v[31:11] == 21'h1FFFFF));
         3'd2:       return !((v[31:12] == 20'h0) || (v[31:12] == 20'hFFFFF)) || v[0];
         3'd3:       return v[11:0] != 12'h0;
         3'd4:       return !((v[31:20] == 12'h0) || (v[31:20] == 12'hFFF)) || v[0];
         default:    return v[31:25] != 7'h0;
      endcase
   endfunction

   // Immediate decoder model used for the round-trip check.
   function automatic logic [31:0] dec_model(input logic [31:0] n, input logic [2:0] s);
      case (s)
         3'd0:    return {{20{n[31]}}, n[31:20]};
         3'd1:    return {{20{n[31]}}, n[31:25], n[11:7]};
         3'd2:    return {{19{n[31]}}, n[31], n[7], n[30:25], n[11:8], 1'b0};
         3'd3:    return {n[31:12], 12'h000};
         3'd4:    return {{11{n[31]}}, n[31], n[19:12], n[20], n[30:21], 1'b0};
         default: return {7'h00, n[31:7]};
      endcase
   endfunction

   // Drive one request; returns the number of cycles it waited for in_ready.
   task automatic send(input logic [31:0] tmpl, input logic [31:0] imm, input logic [2:0] src,
                       input logic [31:0] exp_inst, input logic exp_err, output int waited);
      exp_t e;
      @(negedge clk);
      out_ready = next_ready;
      in_valid  = 1'b1;
      in_tmpl   = tmpl;
      in_imm    = imm;
      in_src    = src;
      #1;
      waited = 0;
      while (!in_ready && waited < 200) begin
         @(negedge clk);
         #1;
         waited++;
      end
      if (!in_ready) begin
         checks++;
         failures++;
         $display("FAIL accept_timeout imm=0x%08h waited=%0d required=<200", imm, waited);
      end else begin
         e.inst = exp_inst;
         e.err  = exp_err;
         e.imm  = imm;
         e.src  = src;
         sb.push_back(e);
         @(posedge clk);
      end
      #1;
      in_valid = 1'b0;
   endtask

   task automatic send_dir(input logic [31:0] tmpl, input logic [31:0] imm, input logic [2:0] src,
                           input logic [31:0] exp_inst, input logic exp_err);
      int w;
      send(tmpl, imm, src, exp_inst, exp_err, w);
   endtask

   task automatic send_rnd(input logic [31:0] tmpl, input logic [31:0] imm, input logic [2:0] src);
      int w;
      send(tmpl, imm, src, enc_model(tmpl, imm, src), err_model(imm, src), w);
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (sb.size() > 0 && n < 1000) begin
         @(negedge clk);
         n++;
      end
      check("drain_empty", 32'(sb.size()), 32'd0);
      @(negedge clk);
      #3;
   endtask

   // Monitor: compare each delivered result against the scoreboard head.
   initial begin
      logic        held;
      logic [31:0] held_inst;
      logic        held_err;
      exp_t        e;
      held = 1'b0;
      held_inst = '0;
      held_err = 1'b0;
      forever begin
         @(negedge clk);
         #3;
         if (rst) begin
            held = 1'b0;
            continue;
         end
         if (held) begin
            check("hold_valid", 32'(out_valid), 32'd1);
            check("hold_inst", out_inst, held_inst);
            check("hold_err", 32'(out_err), 32'(held_err));
         end
         held      = out_valid && !out_ready;
         held_inst = out_inst;
         held_err  = out_err;
         if (out_valid && out_ready) begin
            if (sb.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL unexpected_output inst=0x%08h err=%0b required=no output", out_inst, out_err);
            end else begin
               e = sb.pop_front();
               check("out_inst", out_inst, e.inst);
               check("out_err", 32'(out_err), 32'(e.err));
               check("err_cnt", 32'(err_cnt), 32'(exp_cnt));
               if (!e.err) check("roundtrip", dec_model(out_inst, e.src), e.imm);
               if (e.err && exp_cnt < 255) exp_cnt++;
            end
         end
      end
   end

   initial begin
      #300000;
      $display("FAIL watchdog_timeout time=%0t required=finish before 300000", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      int w;
      logic [31:0] v;
      logic [31:0] imm;
      logic [2:0]  src;

      rst       = 1'b1;
      in_valid  = 1'b0;
      in_tmpl   = '0;
      in_imm    = '0;
      in_src    = '0;
      out_ready = 1'b1;
      #2;
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_out_inst", out_inst, 32'h0);
      check("rst_out_err", 32'(out_err), 32'd0);
      check("rst_err_cnt", 32'(err_cnt), 32'd0);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      #1;
      check("rst_in_ready", 32'(in_ready), 32'd1);

      // Latency: visible one edge after the accepting edge.
      send_dir(32'h00000013, 32'hFFFFF800, 3'b000, 32'h80000013, 1'b0);
      check("lat_not_yet", 32'(out_valid), 32'd0);
      @(posedge clk);
      #1;
      check("lat_valid", 32'(out_valid), 32'd1);
      drain();

      // Directed format vectors.
      send_dir(32'h00000063, 32'h00000003, 3'b010, 32'h00000163, 1'b1);
      send_dir(32'h00000063, 32'h00001000, 3'b010, 32'h80000063, 1'b1);
      send_dir(32'h00000037, 32'h12345000, 3'b011, 32'h12345037, 1'b0);
      send_dir(32'h00000037, 32'h12345001, 3'b011, 32'h12345037, 1'b1);
      send_dir(32'h00002023, 32'hFFFFFFF8, 3'b001, 32'hFE002C23, 1'b0);
      send_dir(32'h0000006F, 32'h00000800, 3'b100, 32'h0010006F, 1'b0);
      send_dir(32'h0000007F, 32'h01FFFFFF, 3'b101, 32'hFFFFFFFF, 1'b0);
      send_dir(32'h0000007F, 32'h02000000, 3'b111, 32'h0000007F, 1'b1);
      drain();
      check("err_cnt_directed", 32'(err_cnt), 32'd4);

      // Backpressure: fill both stages, stall, then resume with a same-cycle shift.
      @(negedge clk);
      out_ready  = 1'b0;
      next_ready = 1'b0;
      send(32'h00000013, 32'h00000001, 3'b000, 32'h00100013, 1'b0, w);
      send(32'h00000013, 32'h00000002, 3'b000, 32'h00200013, 1'b0, w);
      repeat (3) begin
         @(negedge clk);
         #1;
         check("bp_in_ready_low", 32'(in_ready), 32'd0);
         check("bp_out_valid", 32'(out_valid), 32'd1);
      end
      next_ready = 1'b1;
      send(32'h00000013, 32'h00000003, 3'b000, 32'h00300013, 1'b0, w);
      check("bp_no_bubble_wait", 32'(w), 32'd0);
      send(32'h00000013, 32'h00000004, 3'b000, 32'h00400013, 1'b0, w);
      drain();

      // Random round-trip, mostly representable immediates.
      for (int k = 0; k < 40; k++) begin
         v   = $urandom;
         src = 3'($urandom_range(0, 5));
         case (src)
            3'd0, 3'd1: imm = {{20{v[11]}}, v[11:0]};
            3'd2:       imm = {{19{v[12]}}, v[12:1], 1'b0};
            3'd3:       imm = {v[31:12], 12'h000};
            3'd4:       imm = {{11{v[20]}}, v[20:1], 1'b0};
            default:    imm = {7'h00, v[24:0]};
         endcase
         if ($urandom_range(0, 4) == 0) imm = $urandom;
         send_rnd($urandom, imm, src);
      end
      drain();

      // Saturation: enough raw-format errors to pin the counter.
      for (int k = 0; k < 260; k++) begin
         send_dir(32'h00000033, 32'h80000000, 3'b110, 32'h00000033, 1'b1);
      end
      drain();
      check("err_cnt_saturated", 32'(err_cnt), 32'd255);

      // Reset mid-stream discards in-flight requests.
      @(negedge clk);
      out_ready  = 1'b0;
      next_ready = 1'b0;
      send_dir(32'h00000013, 32'h00000005, 3'b000, 32'h00500013, 1'b0);
      send_dir(32'h00000013, 32'h00000006, 3'b000, 32'h00600013, 1'b0);
      @(negedge clk);
      #1;
      rst = 1'b1;
      #1;
      check("amid_out_valid", 32'(out_valid), 32'd0);
      check("amid_err_cnt", 32'(err_cnt), 32'd0);
      sb.delete();
      exp_cnt = 0;
      @(negedge clk);
      #1;
      rst        = 1'b0;
      out_ready  = 1'b1;
      next_ready = 1'b1;
      check("amid_in_ready", 32'(in_ready), 32'd1);
      repeat (5) @(negedge clk);
      #1;
      check("amid_no_output", 32'(out_valid), 32'd0);

      // First error after reset counts from zero.
      send_dir(32'h00000063, 32'h00000003, 3'b010, 32'h00000163, 1'b1);
      drain();
      check("err_cnt_after_rst", 32'(err_cnt), 32'd1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
